// File: rtl/param_misr_collector_pkg.sv
// ============================================================================
//  Module      : misr_pkg
//  Description : Shared FSM state type, default polynomial/seed and the
//                Galois MISR next-state function.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package misr_pkg;

    localparam int MAX_W = 32;

    localparam logic [MAX_W-1:0] DEF_POLY = 32'h0000_001D;
    localparam logic [MAX_W-1:0] DEF_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_e;

    // Operands are zero-extended to MAX_W; w selects the live register width.
    function automatic logic [MAX_W-1:0] misr_next(
        input logic [MAX_W-1:0] sig,
        input logic [MAX_W-1:0] d,
        input logic [MAX_W-1:0] poly,
        input int unsigned      w
    );
        logic             fb;
        logic [MAX_W-1:0] mask;
        fb   = |(sig & (MAX_W'(1) << (w - 1)));
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return ((sig << 1) ^ d ^ (fb ? poly : '0)) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_misr_collector_if.sv
// ============================================================================
//  Module      : param_misr_collector_if
//  Description : Control, tap and status bundle of the MISR collector.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface param_misr_collector_if #(
    parameter int SIG_W = 8,
    parameter int IN_W  = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] window;
    logic [IN_W-1:0]  tap_in;
    logic [IN_W-1:0]  inj_e;
    logic [SIG_W-1:0] exp_sig;
    logic [SIG_W-1:0] sig;
    logic             busy;
    logic             done;
    logic             match;
    logic             inj_seen;

    modport master (
        output start, abort, window, tap_in, inj_e, exp_sig,
        input  sig, busy, done, match, inj_seen
    );

    modport slave (
        input  start, abort, window, tap_in, inj_e, exp_sig,
        output sig, busy, done, match, inj_seen
    );
endinterface

`default_nettype wire

// File: rtl/param_misr_collector_core.sv
// ============================================================================
//  Module      : misr_core
//  Description : Signature register with Galois feedback, load and enable.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module misr_core
    import misr_pkg::*;
#(
    parameter int               SIG_W = 8,
    parameter int               IN_W  = 8,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             m_rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [IN_W-1:0]  d,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_nxt
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    assign sig_nxt = SIG_W'(misr_next(MAX_W'(sig_q), MAX_W'(d), MAX_W'(POLY), SIG_W));

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = sig_nxt;
        end
    end

    always_ff @(posedge clk or negedge m_rst_n) begin
        if (!m_rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/param_misr_collector.sv
// ============================================================================
//  Module      : param_misr_collector
//  Description : Windowed MISR signature collector with fault injection and
//                golden-signature compare.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module param_misr_collector
    import misr_pkg::*;
#(
    parameter int               SIG_W = 8,
    parameter int               IN_W  = 8,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
    parameter int               CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   m_rst_n,
    param_misr_collector_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN  = 2'(ST_RUN);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             inj_seen_q, inj_seen_d;
    logic             core_load, core_en;
    logic [SIG_W-1:0] sig_cur, sig_nxt;
    logic [IN_W-1:0]  d_eff;

    assign d_eff = bus.tap_in ^ bus.inj_e;

    misr_core #(
        .SIG_W (SIG_W),
        .IN_W  (IN_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk     (clk),
        .m_rst_n (m_rst_n),
        .load    (core_load),
        .en      (core_en),
        .d       (d_eff),
        .sig     (sig_cur),
        .sig_nxt (sig_nxt)
    );

    // Abort outranks start, which outranks the normal RUN progression.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        inj_seen_d = inj_seen_q;
        core_load  = 1'b0;
        core_en    = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            match_d = 1'b0;
        end else if (bus.start) begin
            core_load  = 1'b1;
            inj_seen_d = 1'b0;
            cnt_d      = bus.window;
            if (bus.window == '0) begin
                state_d = S_DONE;
                match_d = (SEED == bus.exp_sig);
            end else begin
                state_d = S_RUN;
                match_d = 1'b0;
            end
        end else if (state_q == S_RUN) begin
            core_en    = 1'b1;
            cnt_d      = cnt_q - CNT_W'(1);
            inj_seen_d = inj_seen_q | (|bus.inj_e);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_DONE;
                match_d = (sig_nxt == bus.exp_sig);
            end
        end
    end

    always_ff @(posedge clk or negedge m_rst_n) begin
        if (!m_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            match_q    <= 1'b0;
            inj_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            inj_seen_q <= inj_seen_d;
        end
    end

    assign bus.sig      = sig_cur;
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.match    = match_q & (state_q == S_DONE);
    assign bus.inj_seen = inj_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_param_misr_collector.sv
// ============================================================================
//  Module      : tb_param_misr_collector
//  Description : Directed and model-based checks of param_misr_collector.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_param_misr_collector;

    logic clk     = 1'b0;
    logic m_rst_n = 1'b1;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    param_misr_collector_if #(.SIG_W(4),  .IN_W(4),  .CNT_W(8)) bus4  ();
    param_misr_collector_if #(.SIG_W(2),  .IN_W(1),  .CNT_W(8)) bus2  ();
    param_misr_collector_if #(.SIG_W(8),  .IN_W(8),  .CNT_W(8)) bus8  ();
    param_misr_collector_if #(.SIG_W(32), .IN_W(32), .CNT_W(8)) bus32 ();

    param_misr_collector #(.SIG_W(4), .IN_W(4), .POLY(4'b0011), .SEED(4'b0001), .CNT_W(8))
        u_dut4 (.clk(clk), .m_rst_n(m_rst_n), .bus(bus4));
    param_misr_collector #(.SIG_W(2), .IN_W(1), .POLY(2'b11), .SEED(2'b01), .CNT_W(8))
        u_dut2 (.clk(clk), .m_rst_n(m_rst_n), .bus(bus2));
    param_misr_collector #(.SIG_W(8), .IN_W(8), .POLY(8'h1D), .SEED(8'h01), .CNT_W(8))
        u_dut8 (.clk(clk), .m_rst_n(m_rst_n), .bus(bus8));
    param_misr_collector #(.SIG_W(32), .IN_W(32), .POLY(32'h04C1_1DB7), .SEED(32'h0000_0001), .CNT_W(8))
        u_dut32 (.clk(clk), .m_rst_n(m_rst_n), .bus(bus32));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference written bit-by-bit from the Galois recurrence.
    function automatic logic [31:0] ref_next(input logic [31:0] s, input logic [31:0] d,
                                             input logic [31:0] p, input int w);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < w; i++) begin
            n[i] = d[i] ^ (s[w-1] & p[i]);
            if (i > 0) n[i] = n[i] ^ s[i-1];
        end
        return n;
    endfunction

    task automatic chk4(input string tag, input logic [3:0] s, input logic b,
                        input logic dn, input logic m, input logic inj);
        chk({tag, ".sig"},      32'(bus4.sig),      32'(s));
        chk({tag, ".busy"},     32'(bus4.busy),     32'(b));
        chk({tag, ".done"},     32'(bus4.done),     32'(dn));
        chk({tag, ".match"},    32'(bus4.match),    32'(m));
        chk({tag, ".inj_seen"}, 32'(bus4.inj_seen), 32'(inj));
    endtask

    initial begin
        int          cyc;
        int          w;
        logic [31:0] m2, m8, m32;

        bus4.start = 0; bus4.abort = 0; bus4.window = 0; bus4.tap_in = 0; bus4.inj_e = 0; bus4.exp_sig = 0;
        bus2.start = 0; bus2.abort = 0; bus2.window = 0; bus2.tap_in = 0; bus2.inj_e = 0; bus2.exp_sig = 0;
        bus8.start = 0; bus8.abort = 0; bus8.window = 0; bus8.tap_in = 0; bus8.inj_e = 0; bus8.exp_sig = 0;
        bus32.start = 0; bus32.abort = 0; bus32.window = 0; bus32.tap_in = 0; bus32.inj_e = 0; bus32.exp_sig = 0;

        #2 m_rst_n = 1'b0;
        #1 chk4("reset", 4'b0001, 0, 0, 0, 0);
        #5 m_rst_n = 1'b1;
        step();
        chk4("idle", 4'b0001, 0, 0, 0, 0);

        // Zero-input window of 4
        bus4.start = 1; bus4.window = 4; bus4.exp_sig = 4'b0011;
        step();
        bus4.start = 0;
        chk4("z.start", 4'b0001, 1, 0, 0, 0);
        step(); chk("z.c1", 32'(bus4.sig), 32'b0010);
        step(); chk("z.c2", 32'(bus4.sig), 32'b0100);
        step(); chk4("z.c3", 4'b1000, 1, 0, 0, 0);
        step(); chk4("z.c4", 4'b0011, 0, 1, 1, 0);
        bus4.tap_in = 4'b1111;
        step(); chk4("z.hold", 4'b0011, 0, 1, 1, 0);

        // Single-cycle data, mismatching golden value
        bus4.start = 1; bus4.window = 1; bus4.tap_in = 4'b0001; bus4.exp_sig = 4'b0010;
        step();
        bus4.start = 0;
        step(); chk4("one", 4'b0011, 0, 1, 0, 0);

        // Injection flips tap 0 back to zero
        bus4.start = 1; bus4.inj_e = 4'b0001;
        step();
        bus4.start = 0;
        chk4("inj.start", 4'b0001, 1, 0, 0, 0);
        step(); chk4("inj.done", 4'b0010, 0, 1, 1, 1);
        step(); chk4("inj.sticky", 4'b0010, 0, 1, 1, 1);
        bus4.start = 1; bus4.window = 4; bus4.tap_in = 0; bus4.inj_e = 0;
        step();
        bus4.start = 0;
        chk4("inj.clear", 4'b0001, 1, 0, 0, 0);

        // Abort after two compaction cycles
        step(); chk("ab.c1", 32'(bus4.sig), 32'b0010);
        step(); chk("ab.c2", 32'(bus4.sig), 32'b0100);
        bus4.abort = 1; bus4.start = 1;
        step();
        bus4.abort = 0; bus4.start = 0;
        chk4("ab.idle", 4'b0100, 0, 0, 0, 0);
        step(); chk4("ab.hold", 4'b0100, 0, 0, 0, 0);

        // Restart mid-RUN reloads seed and clears inj_seen
        bus4.start = 1; bus4.window = 4; bus4.inj_e = 4'b0001;
        step();
        bus4.start = 0;
        step(); chk4("rs.c1", 4'b0011, 1, 0, 0, 1);
        bus4.start = 1; bus4.inj_e = 0;
        step();
        bus4.start = 0;
        chk4("rs.restart", 4'b0001, 1, 0, 0, 0);

        // Asynchronous reset mid-RUN
        bus4.inj_e = 4'b0001;
        step(); chk4("rst.pre", 4'b0011, 1, 0, 0, 1);
        #2 m_rst_n = 1'b0;
        #1 chk4("rst.async", 4'b0001, 0, 0, 0, 0);
        step();
        #2 m_rst_n = 1'b1;
        bus4.inj_e = 0; bus4.start = 1; bus4.window = 0; bus4.exp_sig = 4'b0001;
        step();
        bus4.start = 0;
        chk4("w0", 4'b0001, 0, 1, 1, 0);

        // Maximum window: 255 cycles, period-15 sequence returns to seed
        bus4.start = 1; bus4.window = 8'hFF; bus4.exp_sig = 4'b0001;
        step();
        bus4.start = 0;
        cyc = 0;
        while (!bus4.done && cyc < 300) begin
            step();
            cyc++;
        end
        chk("max.cycles", 32'(cyc), 32'd255);
        chk4("max.end", 4'b0001, 0, 1, 1, 0);

        // Model-based windows on the other widths, back-to-back starts
        for (int r = 0; r < 8; r++) begin
            w = $urandom_range(1, 6);
            bus2.start = 1; bus8.start = 1; bus32.start = 1;
            bus2.window = 8'(w); bus8.window = 8'(w); bus32.window = 8'(w);
            step();
            bus2.start = 0; bus8.start = 0; bus32.start = 0;
            m2 = 32'h1; m8 = 32'h1; m32 = 32'h1;
            for (int k = 0; k < w; k++) begin
                bus2.tap_in  = 1'($urandom);
                bus2.inj_e   = 1'($urandom_range(0, 3) == 0);
                bus8.tap_in  = 8'($urandom);
                bus8.inj_e   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
                bus32.tap_in = $urandom;
                bus32.inj_e  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
                m2  = ref_next(m2,  32'(bus2.tap_in ^ bus2.inj_e), 32'h3, 2);
                m8  = ref_next(m8,  32'(bus8.tap_in ^ bus8.inj_e), 32'h1D, 8);
                m32 = ref_next(m32, bus32.tap_in ^ bus32.inj_e, 32'h04C1_1DB7, 32);
                bus2.exp_sig = 2'(m2); bus8.exp_sig = 8'(m8); bus32.exp_sig = m32;
                step();
            end
            chk("rnd2.sig",    32'(bus2.sig),  m2);
            chk("rnd8.sig",    32'(bus8.sig),  m8);
            chk("rnd32.sig",   bus32.sig,      m32);
            chk("rnd.done",    32'({bus2.done, bus8.done, bus32.done}),    32'b111);
            chk("rnd.match",   32'({bus2.match, bus8.match, bus32.match}), 32'b111);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/param_misr_collector.md
PARAM_MISR_COLLECTOR -- requirements
Module: param_misr_collector

Interface
REQ-001 Parameter SIG_W, default 8: signature register width; legal range 2..32.
REQ-002 Parameter IN_W, default 8: observed tap count; legal range 1..SIG_W.
REQ-003 Parameter POLY, default 8'h1D: feedback polynomial taps, SIG_W bits; bit i is feedback into stage i.
REQ-004 Parameter SEED, default 1: signature value loaded on reset and on start; must be non-zero.
REQ-005 Parameter CNT_W, default 8: window counter width.
REQ-006 clk  in  1  sole clock; all state updates on posedge.
REQ-007 m_rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse; reloads SEED and begins a compaction window.
REQ-009 abort  in  1  returns the block to IDLE without completing the window.
REQ-010 window  in  CNT_W  number of compaction cycles; sampled on start.
REQ-011 tap_in  in  IN_W  observed flip-flop outputs.
REQ-012 inj_e  in  IN_W  per-tap fault-injection mask; a set bit inverts that tap before compaction.
REQ-013 exp_sig  in  SIG_W  golden signature; sampled in the cycle the block enters DONE.
REQ-014 sig  out  SIG_W  current signature register.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  high in DONE.
REQ-017 match  out  1  in DONE, 1 when sig == exp_sig; 0 otherwise.
REQ-018 inj_seen  out  1  sticky; set when any inj_e bit is high during RUN.

Function
REQ-019 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-020 IDLE->RUN on start with window != 0; load sig=SEED, cnt=window, clear inj_seen.
REQ-021 start with window == 0: sig=SEED, go directly to DONE with zero compaction cycles.
REQ-022 RUN: every cycle compact the effective input d = tap_in ^ inj_e, zero-extended to SIG_W; decrement cnt.
REQ-023 Compaction (Galois): fb = sig[SIG_W-1]; next[0] = d[0] ^ (fb & POLY[0]); next[i] = sig[i-1] ^ d[i] ^ (fb & POLY[i]) for i>0.
REQ-024 RUN->DONE in the cycle cnt goes 1->0; exactly `window` compaction cycles occur; the signature is stable from DONE onward.
REQ-025 DONE: hold sig; match is registered at DONE entry from the final sig and exp_sig; start in DONE behaves as in IDLE.
REQ-026 abort has priority over start and over the RUN/DONE transitions: next state IDLE; sig is held; match=0; inj_seen is held.
REQ-027 start during RUN restarts the window: reload SEED and window, and clear inj_seen.
REQ-028 In IDLE and DONE, taps are ignored and inj_seen does not change.
REQ-029 cnt does not wrap; window = 2^CNT_W-1 is the maximum.

Reset
REQ-030 On m_rst_n low, asynchronously set: state=IDLE, sig=SEED, cnt=0, match=0, inj_seen=0, busy=0, done=0.
REQ-031 Reset mid-RUN discards the window; the first posedge after deassertion is treated as IDLE.

Structure
REQ-032 Package misr_pkg: state enum, the default POLY/SEED constants, and the misr_next(sig, d, poly) function.
REQ-033 Sub-module misr_core (signature register plus feedback, with load/enable inputs); the FSM and counter live in the top level.
REQ-034 Estimated size: 150-250 lines of RTL.

Verification
Vectors use SIG_W=4, IN_W=4, POLY=4'b0011, SEED=4'b0001.
REQ-035 Zero-input run: start with window=4, tap_in=0, inj_e=0 -> sig sequence 0010, 0100, 1000, 0011; done after the 4th cycle; exp_sig=0011 gives match=1.
REQ-036 Single-cycle data: start with window=1, tap_in=0001 -> sig=0011, done=1; exp_sig=0010 gives match=0.
REQ-037 Injection: same stimulus as REQ-036 plus inj_e=0001 in RUN -> sig=0010 and inj_seen=1; inj_seen stays 1 in DONE and clears on the next start.
REQ-038 Abort: window=4, abort asserted in the 2nd RUN cycle -> state IDLE, sig=0100 held, done=0, match=0.
REQ-039 Reset: m_rst_n low mid-RUN -> all outputs at reset values immediately (no clock edge needed); window=0 start -> done=1 next cycle with sig=0001.
REQ-040 Random regression: compare against a reference model of REQ-023 for SIG_W in {2, 8, 32} and IN_W in {1, SIG_W}, with back-to-back start pulses.
